// File: rtl/display_pkg.sv
// Shared types and constants for the BCD stopwatch display block.
// Holds the count direction encoding and a width helper for the internal counters.
package display_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [3:0] BCD_NINE = 4'd9;

  // Ceiling log2, used to size the prescaler, refresh and index counters.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/bcd_decade.sv
// One BCD decade of the stopwatch counter.
// Advances when enabled and every lower decade is at its rollover value.
module bcd_decade
  import display_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       up_i,
  input  logic       cin_i,
  output logic [3:0] digit_o,
  output logic       cout_o
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  // Carry/borrow out: this and all lower decades sit at 9 (up) or 0 (down).
  assign cout_o  = cin_i & (up_i ? (digit_q == BCD_NINE) : (digit_q == 4'd0));
  assign digit_o = digit_q;

  always_comb begin
    digit_d = digit_q;
    if (clr_i) begin
      digit_d = 4'd0;
    end else if (en_i && cin_i) begin
      if (up_i) digit_d = (digit_q == BCD_NINE) ? 4'd0 : digit_q + 4'd1;
      else      digit_d = (digit_q == 4'd0) ? BCD_NINE : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) digit_q <= 4'd0;
    else       digit_q <= digit_d;
  end

endmodule

// File: rtl/bcd_stopwatch_display.sv
// N-digit BCD stopwatch with run/direction/lap/clear buttons, tick prescaler
// and a multiplexed digit scanner with optional leading-zero blanking.
module bcd_stopwatch_display
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int TICK_DIV    = 50000000,
  parameter int REFRESH_DIV = 25000,
  parameter int BLANK_LZ    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    btn_run,
  input  logic                    btn_dir,
  input  logic                    btn_lap,
  input  logic                    btn_clear,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic                    running,
  output logic                    direction,
  output logic                    lap_active,
  output logic                    wrap,
  output logic [NUM_DIGITS-1:0]   digit_select,
  output logic [3:0]              digit_data,
  output logic                    digit_blank
);

  localparam int CW = 4 * NUM_DIGITS;
  localparam int PW = (clog2(TICK_DIV) < 1) ? 1 : clog2(TICK_DIV);
  localparam int RW = (clog2(REFRESH_DIV) < 1) ? 1 : clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1;

  logic [3:0] btnNow;
  logic [3:0] btnPrev_q;
  logic       runEdge, dirEdge, lapEdge, clearEdge;

  assign btnNow    = {btn_clear, btn_lap, btn_dir, btn_run};
  assign runEdge   = btnNow[0] & ~btnPrev_q[0];
  assign dirEdge   = btnNow[1] & ~btnPrev_q[1];
  assign lapEdge   = btnNow[2] & ~btnPrev_q[2];
  assign clearEdge = btnNow[3] & ~btnPrev_q[3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) btnPrev_q <= 4'd0;
    else       btnPrev_q <= btnNow;
  end

  logic          running_q;
  dir_e          direction_q;
  logic          lapActive_q;
  logic          wrap_q;
  logic [CW-1:0] snapshot_q;
  logic [PW-1:0] presc_q;
  logic          tick;

  assign tick = running_q && (presc_q == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                presc_q <= '0;
    else if (clearEdge||tick) presc_q <= '0;
    else if (running_q)       presc_q <= presc_q + 1'b1;
  end

  logic [CW-1:0]         countBcd;
  logic [NUM_DIGITS:0]   carry;

  assign carry[0] = 1'b1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_decade
    bcd_decade u_decade (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (clearEdge),
      .en_i    (tick),
      .up_i    (direction_q == DIR_UP),
      .cin_i   (carry[g]),
      .digit_o (countBcd[4*g +: 4]),
      .cout_o  (carry[g+1])
    );
  end

  // Clear overrides everything; toggles see the pre-edge state of this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running_q   <= 1'b0;
      direction_q <= DIR_UP;
      lapActive_q <= 1'b0;
      snapshot_q  <= '0;
      wrap_q      <= 1'b0;
    end else begin
      wrap_q <= tick & carry[NUM_DIGITS] & ~clearEdge;
      if (clearEdge) begin
        running_q   <= 1'b0;
        lapActive_q <= 1'b0;
      end else begin
        if (runEdge) running_q <= ~running_q;
        if (dirEdge) direction_q <= (direction_q == DIR_UP) ? DIR_DOWN : DIR_UP;
        if (lapEdge) begin
          if (lapActive_q) begin
            lapActive_q <= 1'b0;
          end else if (running_q) begin
            snapshot_q  <= countBcd;
            lapActive_q <= 1'b1;
          end
        end
      end
    end
  end

  logic [RW-1:0] refresh_q;
  logic [IW-1:0] idx_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_q <= '0;
      idx_q     <= '0;
    end else if (refresh_q == RW'(REFRESH_DIV - 1)) begin
      refresh_q <= '0;
      if (NUM_DIGITS > 1)
        idx_q <= (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      refresh_q <= refresh_q + 1'b1;
    end
  end

  logic [CW-1:0]         dispSrc;
  logic [NUM_DIGITS-1:0] selNext;
  logic [3:0]            dataNext;
  logic                  blankNext;
  logic                  zeroRun;
  logic [NUM_DIGITS-1:0] digitSel_q;
  logic [3:0]            digitData_q;
  logic                  digitBlank_q;

  assign dispSrc = lapActive_q ? snapshot_q : countBcd;

  // zeroRun tracks whether this nibble and all more-significant ones are zero.
  always_comb begin
    selNext   = '1;
    dataNext  = 4'd0;
    blankNext = 1'b0;
    zeroRun   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zeroRun = zeroRun & (dispSrc[4*i +: 4] == 4'd0);
      if (idx_q == IW'(i)) begin
        selNext[i] = 1'b0;
        dataNext   = dispSrc[4*i +: 4];
        blankNext  = (BLANK_LZ != 0) && (i != 0) && zeroRun;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digitSel_q   <= ~(NUM_DIGITS'(1));
      digitData_q  <= 4'd0;
      digitBlank_q <= 1'b0;
    end else begin
      digitSel_q   <= selNext;
      digitData_q  <= dataNext;
      digitBlank_q <= blankNext;
    end
  end

  assign count_bcd    = countBcd;
  assign running      = running_q;
  assign direction    = direction_q;
  assign lap_active   = lapActive_q;
  assign wrap         = wrap_q;
  assign digit_select = digitSel_q;
  assign digit_data   = digitData_q;
  assign digit_blank  = digitBlank_q;

endmodule

// File: tb/tb_bcd_stopwatch_display.sv
// Directed bench for the BCD stopwatch: 2 digits, tick every 4 clocks, scan every 3.
// Cycle-exact expected values are hand-computed from the button timeline.
module tb_bcd_stopwatch_display;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btnRun = 1'b0, btnDir = 1'b0, btnLap = 1'b0, btnClear = 1'b0;
  logic [7:0] countBcd;
  logic       running, direction, lapActive, wrap;
  logic [1:0] digitSelect;
  logic [3:0] digitData;
  logic       digitBlank;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       run, dir, lap, clr;
    int         steps;
    logic [7:0] cnt;
    logic       expRun, expDir, expLap, expWrap;
  } vec_t;

  vec_t tbl[14];

  bcd_stopwatch_display #(
    .NUM_DIGITS (2),
    .TICK_DIV   (4),
    .REFRESH_DIV(3),
    .BLANK_LZ   (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_run     (btnRun),
    .btn_dir     (btnDir),
    .btn_lap     (btnLap),
    .btn_clear   (btnClear),
    .count_bcd   (countBcd),
    .running     (running),
    .direction   (direction),
    .lap_active  (lapActive),
    .wrap        (wrap),
    .digit_select(digitSelect),
    .digit_data  (digitData),
    .digit_blank (digitBlank)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic run, dir, lap, clr, input int steps,
                              input logic [7:0] cnt, input logic r, d, l, w);
    vec_t v;
    v.run = run; v.dir = dir; v.lap = lap; v.clr = clr; v.steps = steps;
    v.cnt = cnt; v.expRun = r; v.expDir = d; v.expLap = l; v.expWrap = w;
    return v;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic run, dir, lap, clr);
    btnRun = run; btnDir = dir; btnLap = lap; btnClear = clr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic checkState(input string name, input logic [7:0] cnt,
                            input logic r, d, l, w);
    checkOutput({name, ".count"}, 32'(countBcd), 32'(cnt));
    checkOutput({name, ".running"}, 32'(running), 32'(r));
    checkOutput({name, ".direction"}, 32'(direction), 32'(d));
    checkOutput({name, ".lap"}, 32'(lapActive), 32'(l));
    checkOutput({name, ".wrap"}, 32'(wrap), 32'(w));
  endtask

  // Watches 8 cycles of scanning; both digits must appear with the given nibble/blank.
  task automatic displayWindow(input string name, input logic [3:0] d1, input logic b1,
                               input logic [3:0] d0, input logic b0);
    bit seen1 = 0, seen0 = 0;
    repeat (8) begin
      step(1);
      if (digitSelect == 2'b01) begin
        seen1 = 1;
        checkOutput({name, ".d1data"}, 32'(digitData), 32'(d1));
        checkOutput({name, ".d1blank"}, 32'(digitBlank), 32'(b1));
      end else if (digitSelect == 2'b10) begin
        seen0 = 1;
        checkOutput({name, ".d0data"}, 32'(digitData), 32'(d0));
        checkOutput({name, ".d0blank"}, 32'(digitBlank), 32'(b0));
      end else begin
        checkOutput({name, ".select"}, 32'(digitSelect), 32'h2);
      end
    end
    checkOutput({name, ".seen1"}, 32'(seen1), 32'd1);
    checkOutput({name, ".seen0"}, 32'(seen0), 32'd1);
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 0, 0, 1,   8'h00, 1, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 40,  8'h10, 1, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 3,   8'h10, 1, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 1,   8'h11, 1, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 347, 8'h97, 1, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 1,   8'h98, 1, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 7,   8'h99, 1, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 1,   8'h00, 1, 0, 0, 1);
    tbl[8]  = mk(0, 0, 0, 0, 1,   8'h00, 1, 0, 0, 0);
    tbl[9]  = mk(0, 1, 0, 0, 1,   8'h00, 1, 1, 0, 0);
    tbl[10] = mk(0, 1, 0, 0, 1,   8'h00, 1, 1, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 1,   8'h99, 1, 1, 0, 1);
    tbl[12] = mk(0, 0, 0, 0, 1,   8'h99, 1, 1, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, 303, 8'h23, 1, 1, 0, 0);

    step(2);
    checkState("reset", 8'h00, 0, 0, 0, 0);
    checkOutput("reset.select", 32'(digitSelect), 32'h2);
    checkOutput("reset.data", 32'(digitData), 32'h0);
    checkOutput("reset.blank", 32'(digitBlank), 32'h0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].run, tbl[i].dir, tbl[i].lap, tbl[i].clr);
      step(tbl[i].steps);
      checkState($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].expRun,
                 tbl[i].expDir, tbl[i].expLap, tbl[i].expWrap);
    end

    // Lap freeze at 23 while counting down underneath.
    applyStimulus(0, 0, 1, 0); step(1); checkState("lapOn", 8'h23, 1, 1, 1, 0);
    applyStimulus(0, 0, 0, 0);
    displayWindow("lapFrozen", 4'd2, 0, 4'd3, 0);
    checkState("lapUnder", 8'h21, 1, 1, 1, 0);
    applyStimulus(0, 0, 1, 0); step(1); checkState("lapOff", 8'h21, 1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0); step(1); checkState("stop", 8'h21, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0); step(1); checkState("stopHold", 8'h21, 0, 1, 0, 0);
    displayWindow("live", 4'd2, 0, 4'd1, 0);
    applyStimulus(0, 0, 1, 0); step(1); checkState("lapIgnored", 8'h21, 0, 1, 0, 0);

    // Clear coinciding with a tick at 45.
    applyStimulus(0, 0, 0, 1); step(1); checkState("clear1", 8'h00, 0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0); step(1); checkState("dirUp", 8'h00, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0); step(1); checkState("restart", 8'h00, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0); step(183); checkState("at45", 8'h45, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1); step(1); checkState("clrTick", 8'h00, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0); step(1); checkState("clrTickAfter", 8'h00, 0, 0, 0, 0);

    // Clear with the prescaler mid-count must restart its phase.
    applyStimulus(1, 0, 0, 0); step(1); checkState("r1", 8'h00, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0); step(3); checkState("r4", 8'h00, 1, 0, 0, 0);
    step(1); checkState("r5", 8'h01, 1, 0, 0, 0);
    step(1); checkState("r6", 8'h01, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1); step(1); checkState("r7clr", 8'h00, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0); step(1); checkState("s1", 8'h00, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0); step(3); checkState("s4", 8'h00, 1, 0, 0, 0);
    step(1); checkState("s5", 8'h01, 1, 0, 0, 0);

    // Leading-zero blanking at 07 and at 00.
    step(24); checkState("s29", 8'h07, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0); step(1); checkState("s30stop", 8'h07, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    displayWindow("lz07", 4'd0, 1, 4'd7, 0);
    applyStimulus(0, 0, 0, 1); step(1); checkState("clr00", 8'h00, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    displayWindow("lz00", 4'd0, 1, 4'd0, 0);

    // Fresh reset, then asynchronous reset in the middle of a cycle.
    reset = 1'b1; step(2); reset = 1'b0;
    applyStimulus(0, 1, 0, 0); step(1); checkState("t1", 8'h00, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0); step(1); checkState("t2", 8'h00, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0); step(3); checkState("t5", 8'h00, 1, 1, 0, 0);
    step(1); checkState("t6", 8'h99, 1, 1, 0, 1);
    checkOutput("t6.select", 32'(digitSelect), 32'h1);
    checkOutput("t6.blank", 32'(digitBlank), 32'h1);
    #3 reset = 1'b1;
    #1;
    checkState("asyncRst", 8'h00, 0, 0, 0, 0);
    checkOutput("asyncRst.select", 32'(digitSelect), 32'h2);
    checkOutput("asyncRst.data", 32'(digitData), 32'h0);
    checkOutput("asyncRst.blank", 32'(digitBlank), 32'h0);
    step(2);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
